// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Holds the arbitration state enum, the requester-id enum and the
// default address/data widths of the DMEM BRAM (16384 x 32).
package dmem_arb_pkg;

    localparam int AWIDTH_DEF   = 14;
    localparam int DWIDTH_DEF   = 32;
    localparam int STARVE_W     = 4;

    typedef enum logic {
        SHARED = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_arbiter_prio_starve.sv
// Two-input fixed-priority grant with a starvation counter.
// The high-priority side wins contested cycles until the low-priority side
// has lost STARVE_LIMIT contested grants in a row; it then wins one grant.
// lo_only selects exclusive mode: only the low side may be granted and the
// starvation counter is held at zero.
module arb_prio_starve
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hi_valid,
    input  logic lo_valid,
    input  logic lo_only,
    output logic hi_grant,
    output logic lo_grant
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    // Grant decision from current valids, mode and starvation count.
    always_comb begin
        hi_grant = 1'b0;
        lo_grant = 1'b0;
        if (lo_only) begin
            lo_grant = lo_valid;
        end else if (hi_valid && lo_valid) begin
            if (starve_q == LIMIT) begin
                lo_grant = 1'b1;
            end else begin
                hi_grant = 1'b1;
            end
        end else begin
            hi_grant = hi_valid;
            lo_grant = lo_valid;
        end
    end

    // Count consecutive contested losses of the low side, saturating at LIMIT.
    always_comb begin
        starve_d = starve_q;
        if (lo_only || !lo_valid || lo_grant) begin
            starve_d = '0;
        end else if (hi_grant && (starve_q < LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-ported DMEM BRAM between the CPU data port and
// the serial program loader. CPU has fixed priority with a starvation limit;
// the loader can lock the memory for uninterrupted image bursts.
// Optional macro ARB_PERF_CNT_EN enables the CPU stall-cycle counter;
// without it stall_cnt is tied to zero.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [AWIDTH-1:0]     cpu_req_addr,
    input  logic [DWIDTH-1:0]     cpu_req_wdata,
    input  logic [DWIDTH/8-1:0]   cpu_req_wbe,
    output logic                  cpu_resp_valid,
    output logic [DWIDTH-1:0]     cpu_resp_rdata,
    input  logic                  ldr_req_valid,
    output logic                  ldr_req_ready,
    input  logic [AWIDTH-1:0]     ldr_req_addr,
    input  logic [DWIDTH-1:0]     ldr_req_wdata,
    input  logic [DWIDTH/8-1:0]   ldr_req_wbe,
    input  logic                  ldr_req_lock,
    output logic                  ldr_resp_valid,
    output logic [DWIDTH-1:0]     ldr_resp_rdata,
    output logic                  mem_en,
    output logic [DWIDTH/8-1:0]   mem_we,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_din,
    input  logic [DWIDTH-1:0]     mem_dout,
    output logic [31:0]           stall_cnt
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       locked_now;
    logic       cpu_gnt;
    logic       ldr_gnt;
    logic       rd_pend_q;
    logic       rd_pend_d;
    req_id_e    rd_owner_q;
    req_id_e    rd_owner_d;

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHARED;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter lock on a locked loader handshake; leave as soon as lock drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHARED:  if (ldr_gnt && ldr_req_lock) state_d = LOCKED;
            LOCKED:  if (!ldr_req_lock)           state_d = SHARED;
            default: state_d = SHARED;
        endcase
    end

    // The unlock cycle is already arbitrated as shared.
    always_comb begin
        locked_now = (state_q == LOCKED) && ldr_req_lock;
    end

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .hi_valid (cpu_req_valid),
        .lo_valid (ldr_req_valid),
        .lo_only  (locked_now),
        .hi_grant (cpu_gnt),
        .lo_grant (ldr_gnt)
    );

    assign cpu_req_ready = cpu_gnt;
    assign ldr_req_ready = ldr_gnt;

    // Steer the granted requester onto the BRAM port; idle port is disabled.
    always_comb begin
        mem_en   = cpu_gnt | ldr_gnt;
        mem_we   = '0;
        mem_addr = cpu_req_addr;
        mem_din  = cpu_req_wdata;
        if (ldr_gnt) begin
            mem_we   = ldr_req_wbe;
            mem_addr = ldr_req_addr;
            mem_din  = ldr_req_wdata;
        end else if (cpu_gnt) begin
            mem_we   = cpu_req_wbe;
        end
    end

    // Remember whether this cycle issued a read and who owns its response.
    always_comb begin
        rd_pend_d  = mem_en && (mem_we == '0);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = ldr_gnt ? REQ_LDR : REQ_CPU;
        end
    end

    // Read-response tracking; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_resp_valid = rd_pend_q && (rd_owner_q == REQ_CPU);
    assign ldr_resp_valid = rd_pend_q && (rd_owner_q == REQ_LDR);
    assign cpu_resp_rdata = mem_dout;
    assign ldr_resp_rdata = mem_dout;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_q;

    // Count every cycle the CPU is waiting; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (cpu_req_valid && !cpu_req_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic [AW-1:0] cpu_req_addr = '0;
    logic [DW-1:0] cpu_req_wdata = '0;
    logic [BW-1:0] cpu_req_wbe = '0;
    logic          cpu_resp_valid;
    logic [DW-1:0] cpu_resp_rdata;
    logic          ldr_req_valid = 1'b0;
    logic          ldr_req_ready;
    logic [AW-1:0] ldr_req_addr = '0;
    logic [DW-1:0] ldr_req_wdata = '0;
    logic [BW-1:0] ldr_req_wbe = '0;
    logic          ldr_req_lock = 1'b0;
    logic          ldr_resp_valid;
    logic [DW-1:0] ldr_resp_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AWIDTH       (AW),
        .DWIDTH       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_wbe    (cpu_req_wbe),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .ldr_req_valid  (ldr_req_valid),
        .ldr_req_ready  (ldr_req_ready),
        .ldr_req_addr   (ldr_req_addr),
        .ldr_req_wdata  (ldr_req_wdata),
        .ldr_req_wbe    (ldr_req_wbe),
        .ldr_req_lock   (ldr_req_lock),
        .ldr_resp_valid (ldr_resp_valid),
        .ldr_resp_rdata (ldr_resp_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .stall_cnt      (stall_cnt)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 32'h10)  return 32'hDEADBEEF;
        if (i == 32'h200) return 32'h12345678;
        return (i * 32'h9E3779B9) + 32'h1;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Write-first BRAM model driven by the arbiter's memory port.
    logic [31:0] bram [0:16383];
    logic        pre_done = 1'b0;
    always @(posedge clk) begin
        if (!pre_done) begin
            for (int i = 0; i < 16384; i++) bram[i] <= init_val(i);
            pre_done <= 1'b1;
        end else if (mem_en) begin
            bram[mem_addr] <= merge(bram[mem_addr], mem_din, mem_we);
            mem_dout       <= merge(bram[mem_addr], mem_din, mem_we);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, lock flag, contested-loss count,
    // pending response and stall count, advanced once per cycle.
    logic [31:0] ref_mem [0:16383];
    bit          m_locked;
    int          m_starve;
    bit          m_pend;
    bit          m_pend_ldr;
    logic [31:0] m_pend_data;
    int unsigned m_stall;

    initial begin : compare
        int          g;
        bit          shared;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        logic [BW-1:0] a_wbe;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_locked = 0; m_starve = 0; m_pend = 0; m_pend_ldr = 0; m_stall = 0;
                chk("rst_cpu_resp_valid", {31'b0, cpu_resp_valid}, 32'd0);
                chk("rst_ldr_resp_valid", {31'b0, ldr_resp_valid}, 32'd0);
                chk("rst_stall_cnt", stall_cnt, 32'd0);
            end else begin
                shared = !(m_locked && ldr_req_lock);
                g = 0;
                if (shared) begin
                    if (cpu_req_valid && ldr_req_valid) g = (m_starve == LIM) ? 2 : 1;
                    else if (cpu_req_valid) g = 1;
                    else if (ldr_req_valid) g = 2;
                end else if (ldr_req_valid) begin
                    g = 2;
                end
                a_addr = (g == 2) ? ldr_req_addr  : cpu_req_addr;
                a_data = (g == 2) ? ldr_req_wdata : cpu_req_wdata;
                a_wbe  = (g == 2) ? ldr_req_wbe   : (g == 1) ? cpu_req_wbe : 4'b0;

                chk("cpu_req_ready", {31'b0, cpu_req_ready}, {31'b0, g == 1});
                chk("ldr_req_ready", {31'b0, ldr_req_ready}, {31'b0, g == 2});
                chk("mem_en", {31'b0, mem_en}, {31'b0, g != 0});
                chk("mem_we", {28'b0, mem_we}, {28'b0, a_wbe});
                if (g != 0) begin
                    chk("mem_addr", {18'b0, mem_addr}, {18'b0, a_addr});
                    chk("mem_din", mem_din, a_data);
                end
                chk("cpu_resp_valid", {31'b0, cpu_resp_valid}, {31'b0, m_pend && !m_pend_ldr});
                chk("ldr_resp_valid", {31'b0, ldr_resp_valid}, {31'b0, m_pend && m_pend_ldr});
                if (m_pend) begin
                    chk("cpu_resp_rdata", cpu_resp_rdata, m_pend_data);
                    chk("ldr_resp_rdata", ldr_resp_rdata, m_pend_data);
                end
`ifdef ARB_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, m_stall);
`else
                chk("stall_cnt", stall_cnt, 32'd0);
`endif
                // advance model
                m_pend     = (g != 0) && (a_wbe == 0);
                m_pend_ldr = (g == 2);
                if (m_pend) m_pend_data = ref_mem[a_addr];
                if (g != 0 && a_wbe != 0) ref_mem[a_addr] = merge(ref_mem[a_addr], a_data, a_wbe);
                if (!shared || !ldr_req_valid || g == 2) m_starve = 0;
                else if (g == 1) m_starve = m_starve + 1;
                m_locked = ldr_req_lock && (!shared || g == 2);
                if (cpu_req_valid && g != 1) m_stall = m_stall + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req_valid = 0;
        ldr_req_valid = 0;
        ldr_req_lock  = 0;
    endtask

    task automatic cpu_set(logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
        cpu_req_valid = 1; cpu_req_addr = a; cpu_req_wdata = d; cpu_req_wbe = be;
    endtask

    task automatic ldr_set(logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be, logic lk);
        ldr_req_valid = 1; ldr_req_addr = a; ldr_req_wdata = d; ldr_req_wbe = be; ldr_req_lock = lk;
    endtask

    initial begin : main
        string pat;
        bit    cpu_acc;
        bit    ldr_acc;
        repeat (3) step();
        rst_n = 1;
        step();

        // 1: CPU-only read of preloaded word
        cpu_set(14'h10, 32'h0, 4'h0);
        @(negedge clk); chk("s1_cpu_ready", {31'b0, cpu_req_ready}, 32'd1);
        step(); idle();
        @(negedge clk);
        chk("s1_resp_valid", {31'b0, cpu_resp_valid}, 32'd1);
        chk("s1_rdata", cpu_resp_rdata, 32'hDEADBEEF);
        chk("s1_ldr_resp_valid", {31'b0, ldr_resp_valid}, 32'd0);
        $display("txn s1 cpu read 0x0010 -> 0x%08h", cpu_resp_rdata);
        step();

        // 2: starvation pattern
        pat = "";
        cpu_set(14'h20, 32'h0, 4'h0);
        ldr_set(14'h30, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat = {pat, cpu_req_ready ? "C" : (ldr_req_ready ? "L" : "-")};
            step();
        end
        idle();
        checks++;
        if (pat != "CCCCLCCCCL") begin
            errors++;
            $display("FAIL s2_grant_pattern actual=%s expected=CCCCLCCCCL", pat);
        end
        $display("txn s2 grant pattern %s", pat);
        step();

        // 3: loader lock burst with CPU waiting
        ldr_set(14'h100, 32'h11, 4'hF, 1'b1);
        @(negedge clk); chk("s3_ldr_ready0", {31'b0, ldr_req_ready}, 32'd1);
        step();
        ldr_set(14'h101, 32'h22, 4'hF, 1'b1);
        cpu_set(14'h101, 32'h0, 4'h0);
        @(negedge clk); chk("s3_cpu_blocked1", {31'b0, cpu_req_ready}, 32'd0);
        step();
        ldr_set(14'h102, 32'h33, 4'hF, 1'b1);
        @(negedge clk); chk("s3_cpu_blocked2", {31'b0, cpu_req_ready}, 32'd0);
        step();
        ldr_req_valid = 0; ldr_req_lock = 0;
        @(negedge clk); chk("s3_cpu_unlock_ready", {31'b0, cpu_req_ready}, 32'd1);
        step(); idle();
        @(negedge clk);
        chk("s3_resp_valid", {31'b0, cpu_resp_valid}, 32'd1);
        chk("s3_rdata", cpu_resp_rdata, 32'h22);
        $display("txn s3 cpu read 0x0101 after lock -> 0x%08h", cpu_resp_rdata);
        step();

        // 4: byte-enable write then read back
        cpu_set(14'h200, 32'h0000AB00, 4'b0010);
        step();
        cpu_set(14'h200, 32'h0, 4'h0);
        step(); idle();
        @(negedge clk);
        chk("s4_resp_valid", {31'b0, cpu_resp_valid}, 32'd1);
        chk("s4_rdata", cpu_resp_rdata, 32'h1234AB78);
        $display("txn s4 byte write/read 0x0200 -> 0x%08h", cpu_resp_rdata);
        step();

        // 5: reset between read handshake and response
        cpu_set(14'h10, 32'h0, 4'h0);
        @(negedge clk);
        step();
        rst_n = 0; idle();
        @(negedge clk); chk("s5_no_resp", {31'b0, cpu_resp_valid}, 32'd0);
        step(); step();
        rst_n = 1;
        cpu_set(14'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("s5_ready", {31'b0, cpu_req_ready}, 32'd1);
        chk("s5_stall", stall_cnt, 32'd0);
        step(); idle();
        @(negedge clk);
        chk("s5_resp_rdata", cpu_resp_rdata, 32'hDEADBEEF);
        $display("txn s5 reset mid-read, post-reset read -> 0x%08h", cpu_resp_rdata);
        step();

        // 6: CPU held off for 7 locked cycles
        ldr_set(14'h300, 32'h5, 4'hF, 1'b1);
        step();
        cpu_set(14'h300, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            ldr_set(14'(32'h301 + i), 32'(i), 4'hF, 1'b1);
            step();
        end
        ldr_req_valid = 0; ldr_req_lock = 0;
        @(negedge clk);
        chk("s6_cpu_ready", {31'b0, cpu_req_ready}, 32'd1);
`ifdef ARB_PERF_CNT_EN
        chk("s6_stall_cnt", stall_cnt, 32'd7);
`else
        chk("s6_stall_cnt", stall_cnt, 32'd0);
`endif
        $display("txn s6 stall_cnt after lock = %0d", stall_cnt);
        step(); idle();
        step();

        // randomized traffic on a small address window
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cpu_acc = cpu_req_valid && cpu_req_ready;
            ldr_acc = ldr_req_valid && ldr_req_ready;
            step();
            if (!cpu_req_valid || cpu_acc) begin
                cpu_req_valid = ($urandom_range(0, 3) != 0);
                cpu_req_addr  = 14'($urandom_range(0, 15));
                cpu_req_wdata = $urandom;
                cpu_req_wbe   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            end
            if (!ldr_req_valid || ldr_acc) begin
                ldr_req_valid = ($urandom_range(0, 2) != 0);
                ldr_req_addr  = 14'($urandom_range(0, 15));
                ldr_req_wdata = $urandom;
                ldr_req_wbe   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
                if ($urandom_range(0, 7) == 0) ldr_req_lock = !ldr_req_lock;
            end
            if (n % 500 == 0)
                $display("txn rand %0d cpu_v=%0b ldr_v=%0b lock=%0b", n, cpu_req_valid, ldr_req_valid, ldr_req_lock);
        end
        idle();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported data BRAM (16384 x 32 words) between two requesters: the CPU data port (CPU) and the serial program loader (LDR). Fixed CPU priority with a starvation limit, plus a loader lock mode for uninterrupted program-image bursts. Reads return data one cycle after acceptance. Sits between the CPU memory stage, the loader and the DMEM instance.

Parameters:
AWIDTH, 14, word-address width (16384 words)
DWIDTH, 32, data width; byte enables are DWIDTH/8 wide
STARVE_LIMIT, 4, consecutive contested CPU grants before the loader is forced one grant; range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  CPU request accepted this cycle
cpu_req_addr  in  AWIDTH  CPU word address
cpu_req_wdata  in  DWIDTH  CPU write data
cpu_req_wbe  in  DWIDTH/8  CPU byte enables; all zero means read
cpu_resp_valid  out  1  CPU read data valid
cpu_resp_rdata  out  DWIDTH  CPU read data
ldr_req_valid  in  1  loader request valid
ldr_req_ready  out  1  loader request accepted
ldr_req_addr  in  AWIDTH  loader word address
ldr_req_wdata  in  DWIDTH  loader write data
ldr_req_wbe  in  DWIDTH/8  loader byte enables; all zero means read
ldr_req_lock  in  1  loader requests exclusive ownership
ldr_resp_valid  out  1  loader read data valid
ldr_resp_rdata  out  DWIDTH  loader read data
mem_en  out  1  BRAM enable
mem_we  out  DWIDTH/8  BRAM byte write enables
mem_addr  out  AWIDTH  BRAM address
mem_din  out  DWIDTH  BRAM write data
mem_dout  in  DWIDTH  BRAM read data, valid one cycle after mem_en
stall_cnt  out  32  CPU stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): state=SHARED, starve_cnt=0, both resp_valid=0, rd_owner=CPU, stall_cnt=0. In-flight read is dropped and no response is issued.
- Handshake: a request transfers on the rising edge where valid && ready. Ready is combinational from valids and state, never depends on ready itself. Requesters hold addr/data/wbe stable while valid && !ready.
- mem_* is a combinational mux of the granted requester. mem_en = any handshake. mem_we = granted wbe. With no grant, mem_en=0 and mem_we=0.
- Grant in SHARED:
  - Only one valid: that requester is granted.
  - Both valid: CPU is granted unless starve_cnt == STARVE_LIMIT, in which case LDR is granted.
- starve_cnt (4 bits):
  - Increments on a CPU grant while ldr_req_valid=1.
  - Clears on an LDR grant or when ldr_req_valid=0.
  - Never exceeds STARVE_LIMIT.
- State machine:
  - SHARED -> LOCKED on an LDR handshake with ldr_req_lock=1.
  - LOCKED: cpu_req_ready=0; LDR is granted whenever it is valid; starve_cnt is held at 0.
  - LOCKED -> SHARED on the first cycle with ldr_req_lock=0. That same cycle is already arbitrated as SHARED (combinational).
- Read response:
  - On a read handshake (wbe==0), the next cycle asserts the owner's resp_valid for exactly 1 cycle.
  - resp_rdata = mem_dout. Both resp_rdata buses carry mem_dout; only resp_valid is steered.
  - Back-to-back reads sustain 1 per cycle.
  - Writes produce no response and complete at the handshake.
- Simultaneous events: a read-after-write to the same address on consecutive cycles returns the new data (BRAM write-first, required of DMEM).

Optional Feature:
ARB_PERF_CNT_EN
- Defined: stall_cnt increments every cycle with cpu_req_valid && !cpu_req_ready. It wraps at 2^32 and is cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {SHARED, LOCKED};
  - requester-id enum {REQ_CPU, REQ_LDR};
  - default AWIDTH/DWIDTH constants.
- One natural sub-module, arb_prio_starve: two-input priority grant plus the starve counter. This isolates the policy so it can be reused for the IMEM loader port.

Test Plan:
1. CPU only: read addr 0x0010 preloaded with 0xDEADBEEF -> cpu_req_ready=1 the same cycle; cpu_resp_valid=1 the next cycle with rdata 0xDEADBEEF; ldr_resp_valid stays 0.
2. Starvation: both valid continuously for 10 cycles, STARVE_LIMIT=4 -> grant pattern C,C,C,C,L,C,C,C,C,L.
3. Lock: loader writes 0x11,0x22,0x33 to 0x100..0x102 with lock=1 while the CPU holds valid -> cpu_req_ready=0 throughout. After lock drops, the CPU is granted that same cycle, and a CPU read of 0x101 returns 0x22.
4. Byte write: CPU writes wbe=4'b0010, wdata=0x0000AB00 to a word holding 0x12345678 -> a subsequent read returns 0x1234AB78.
5. Reset mid-read: assert rst_n=0 between the read handshake and the response -> no resp_valid. After release, state=SHARED, ready behaves per scenario 1, and stall_cnt=0.
6. With ARB_PERF_CNT_EN: CPU held off 7 cycles by lock -> stall_cnt=7. Without the macro, stall_cnt=0.
